// File: rtl/bnn_weight_loader.sv
// Weight loader: walks conv1, conv2 and FC weight memories in fixed order, generating every core write address.
// Latency: a word accepted in cycle t is written to the core in cycle t+1; a full load takes 1650 cycles minimum.
// Backpressure: w_ready is high only while loading; the core never stalls, so each accepted word is one write.
// Optional feature macro WLOAD_CHECKSUM_EN: adds a trailing checksum word, a CHECK state and a sticky load_err.
module bnn_weight_loader #(
    parameter int bW        = 8,
    parameter int L1_WORDS  = 90,
    parameter int L1_OFFS   = 18,
    parameter int L2_WORDS  = 1080,
    parameter int L2_OFFS   = 60,
    parameter int FC_OUTS   = 10,
    parameter int FC_CHUNKS = 48
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [24+bW:0]  w_data,
    output logic            kernel_in_valid,
    output logic [1:0]      kernel_layer,
    output logic [10:0]     kernel_addr,
    output logic [bW-1:0]   kernel_offset,
    output logic [24:0]     kernel_bits,
    output logic            busy,
    output logic            weights_loaded,
    output logic            load_err
);

    localparam int FC_WORDS = FC_OUTS * FC_CHUNKS;
    localparam int CW       = (FC_CHUNKS > 1) ? $clog2(FC_CHUNKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD1  = 3'd1,
        S_LOAD2  = 3'd2,
        S_LOADFC = 3'd3,
`ifdef WLOAD_CHECKSUM_EN
        S_CHECK  = 3'd4,
`endif
        S_DONE   = 3'd5
    } state_t;

    state_t        state, state_nxt, phase_next;
    logic [10:0]   cnt, cnt_nxt, phase_last;
    logic [CW-1:0] chunk, chunk_nxt;
    logic [1:0]    wr_layer;
    logic          accept, wr_en, busy_nxt, clr, off_keep;
`ifdef WLOAD_CHECKSUM_EN
    logic          chk_eval;
`endif

    // Next-state, word counter and write-enable decode
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        chunk_nxt  = '0;
        wr_en      = 1'b0;
        wr_layer   = 2'd0;
        clr        = 1'b0;
        off_keep   = 1'b0;
        phase_last = '0;
        phase_next = S_DONE;
`ifdef WLOAD_CHECKSUM_EN
        chk_eval   = 1'b0;
`endif
        accept     = w_valid & w_ready;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_LOAD1;
                    cnt_nxt   = '0;
                    clr       = 1'b1;
                end
            end
            S_LOAD1: begin
                wr_layer   = 2'd1;
                phase_last = 11'(L1_WORDS - 1);
                phase_next = S_LOAD2;
                off_keep   = (cnt < 11'(L1_OFFS));
            end
            S_LOAD2: begin
                wr_layer   = 2'd2;
                phase_last = 11'(L2_WORDS - 1);
                phase_next = S_LOADFC;
                off_keep   = (cnt < 11'(L2_OFFS));
            end
            S_LOADFC: begin
                wr_layer   = 2'd3;
                phase_last = 11'(FC_WORDS - 1);
`ifdef WLOAD_CHECKSUM_EN
                phase_next = S_CHECK;
`else
                phase_next = S_DONE;
`endif
                // FC scale lives only in the first chunk of each output
                off_keep   = (chunk == '0);
                chunk_nxt  = chunk;
            end
`ifdef WLOAD_CHECKSUM_EN
            S_CHECK: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (accept) begin
                    state_nxt = S_DONE;
                    chk_eval  = 1'b1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        // Shared load-phase sequencing; a word accepted alongside abort is still written
        if (wr_layer != 2'd0) begin
            wr_en = accept;
            if (abort) begin
                state_nxt = S_IDLE;
            end else if (accept) begin
                if (cnt == phase_last) begin
                    state_nxt = phase_next;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
                if (state == S_LOADFC) begin
                    chunk_nxt = (chunk == CW'(FC_CHUNKS - 1)) ? '0 : chunk + CW'(1);
                end
            end
        end

        busy_nxt = (state_nxt == S_LOAD1) || (state_nxt == S_LOAD2) || (state_nxt == S_LOADFC);
`ifdef WLOAD_CHECKSUM_EN
        busy_nxt = busy_nxt || (state_nxt == S_CHECK);
`endif
    end

    // State, word counter and FC chunk counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            chunk <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            chunk <= chunk_nxt;
        end
    end

    // Registered core write port and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ready         <= 1'b0;
            busy            <= 1'b0;
            kernel_in_valid <= 1'b0;
            kernel_layer    <= 2'd0;
            kernel_addr     <= '0;
            kernel_offset   <= '0;
            kernel_bits     <= '0;
            weights_loaded  <= 1'b0;
        end else begin
            w_ready         <= busy_nxt;
            busy            <= busy_nxt;
            kernel_in_valid <= wr_en;
            if (wr_en) begin
                kernel_layer  <= wr_layer;
                kernel_addr   <= cnt;
                kernel_offset <= off_keep ? w_data[24+bW:25] : '0;
                kernel_bits   <= w_data[24:0];
            end else if (!busy_nxt) begin
                kernel_layer  <= 2'd0;
            end
            // Rises one cycle after entering DONE so it trails the final write strobe
            weights_loaded  <= (state == S_DONE) && (state_nxt == S_DONE) && !load_err;
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    logic [15:0] csum;
    logic        err_q;

    // Running 16-bit sum over loaded words; the trailing word is compared against it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (clr) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                csum <= csum + w_data[15:0];
            end
            if (chk_eval && (w_data[15:0] != csum)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: doc/bnn_weight_loader.md
# bnn_weight_loader

Sequencer that streams binary kernels, thresholds and FC weight chunks from an external word source into the BNN inference core's weight write port (`kernel_in_valid` / `kernel_layer` / `kernel_addr` / `kernel_offset` / kernel bits). It walks conv1, then conv2, then FC in fixed order, generating every address itself. It raises `weights_loaded` only when all three weight memories are fully written, which gates image acceptance upstream of the core.

## Interface
- `bW`, 8, offset/threshold width
- `L1_WORDS`, 90, conv1 kernel writes; offset field written for addr < `L1_OFFS`
- `L1_OFFS`, 18, conv1 thresholds
- `L2_WORDS`, 1080, conv2 kernel writes
- `L2_OFFS`, 60, conv2 thresholds
- `FC_OUTS`, 10, FC outputs
- `FC_CHUNKS`, 48, 20-bit binary-weight chunks per FC output (960/20)

Ports:
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  begin a full load (pulse; sampled in IDLE or DONE only)
- `abort`  in  1  cancel the load in progress
- `w_valid`  in  1  stream word valid
- `w_ready`  out  1  stream word ready
- `w_data`  in  25+`bW`  [24+`bW`:25] offset, [24:0] kernel bits (row-major 5x5; FC uses [19:0])
- `kernel_in_valid`  out  1  one-cycle write strobe to core
- `kernel_layer`  out  2  1=conv1, 2=conv2, 3=fc, 0 when idle
- `kernel_addr`  out  11  write address
- `kernel_offset`  out  `bW`  threshold/FC scale
- `kernel_bits`  out  25  kernel bits
- `busy`  out  1  load in progress
- `weights_loaded`  out  1  all memories valid
- `load_err`  out  1  sticky checksum failure (see Configuration)

## Operation
- States: IDLE, LOAD1, LOAD2, LOADFC, [CHECK], DONE.
- IDLE/DONE + `start` → LOAD1. Also: clear `weights_loaded` and `load_err`, and zero the word counter.
- `w_ready` = 1 exactly in LOAD*/CHECK states. The core never back-pressures.
- Each accepted word (`w_valid & w_ready`) produces one write with the current `kernel_addr`, and the counter increments.
- LOAD1: addr 0..89. Last accept → LOAD2, counter reset.
- LOAD2: addr 0..1079. Last accept → LOADFC.
- LOADFC: word k has output o = k / `FC_CHUNKS` and chunk c = k % `FC_CHUNKS`.
  - addr = o*`FC_CHUNKS`+c, range 0..479.
  - Offset field is meaningful only for c = 0.
  - Last accept → CHECK if configured, else DONE.
- DONE: `weights_loaded`=1, held until the next `start` or reset.
- `start` while `busy` is ignored.
- `abort` in any LOAD*/CHECK state → IDLE next cycle.
  - `weights_loaded`=0; any write strobe for a word accepted that cycle still issues.
  - The accept counter is not advanced past abort.
  - `abort` in IDLE/DONE has no effect.
- `abort` and `start` in the same cycle: `abort` wins when busy; `start` wins when idle.
- Layer totals are compile-time. Counters are 11 bits and never wrap inside a phase.

## Timing
- All outputs registered.
- Reset values: `w_ready`, `kernel_in_valid`, `busy`, `weights_loaded`, `load_err` = 0; `kernel_layer`, `kernel_addr`, `kernel_offset`, `kernel_bits` = 0. State = IDLE.
- Word accepted at cycle t → `kernel_in_valid`=1 at t+1 with its addr/layer/data; otherwise strobe is 0. Data outputs hold their last value.
- `start` at t → `busy`=1, `w_ready`=1 at t+1.
- Back-to-back accepts give one write per cycle: 1650 cycles minimum for a full load (+1 with checksum).
- `weights_loaded` rises the cycle after the final write strobe, or the cycle after the checksum word.
- Reset mid-load returns everything to reset values in one cycle. Partially written core memories are not cleared by this block.

## Configuration
- `WLOAD_CHECKSUM_EN` defined:
  - A 16-bit running sum (mod 2^16) accumulates over the low 16 bits of every accepted load word.
  - CHECK state accepts one extra word; its [15:0] is compared to the sum.
  - Match → DONE with `weights_loaded`=1.
  - Mismatch → DONE with `weights_loaded`=0 and `load_err`=1 (sticky until `start`/reset).
  - The checksum word produces no write strobe.
- Undefined: CHECK state, accumulator and comparator absent. LOADFC goes directly to DONE; `load_err` tied 0.

## Test plan
- Reset, then `start`, then 1650 words streamed with `w_valid` held high:
  - 90 strobes at layer 1, addr 0..89.
  - 1080 at layer 2, addr 0..1079.
  - 480 at layer 3, addr 0..479.
  - `weights_loaded`=1 one cycle after the last strobe.
- `w_valid` toggled randomly at 50% → strobe count and address sequence identical to continuous streaming; no strobe in cycles following a non-accept.
- `abort` at conv2 word 500 → next cycle IDLE, `busy`=0, `w_ready`=0. A new `start` restarts at layer 1 addr 0.
- `start` pulsed during LOAD1 → ignored; address sequence unaffected. `start` in DONE → `weights_loaded` drops and a reload begins.
- `rst_n` low at FC word 100 → all outputs 0 next cycle; state IDLE.
- With `WLOAD_CHECKSUM_EN`, all-ones words: sum = 1650*0xFFFF mod 2^16 = 0xF98E.
  - Checksum word 0xF98E → `weights_loaded`=1.
  - Checksum word 0x0000 → `load_err`=1, `weights_loaded`=0.
